adc_ltc2308_ctrl: RTL
=====================

Name: adc_ltc2308_ctrl

Overview:
Serial master for the on-board LTC2308 12-bit, 8-channel SPI ADC. It runs free-running convert/shift frames and sends the caller-selected channel in each frame's config word. It returns the 12-bit conversion on a parallel bus, tagged with the channel it belongs to. It is the ADC-side counterpart of the joystick and other analogue-input consumers, which drive chan and read result.

Parameters:
CLK_DIV, 2, clk cycles per SCK half-period (SCK = clk/(2*CLK_DIV)); legal range 1..255
CONV_CYCLES, 80, clk cycles CONVST is held high (conversion time; 1.6 us at 50 MHz)
GAP_CYCLES, 2, idle clk cycles with CONVST low between the end of the shift and the next frame

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous, active-low reset
en  input  1  1 = run frames continuously; 0 = stop after the current frame completes
chan  input  3  requested single-ended channel 0..7
result  output  12  last completed conversion, held between updates
result_chan  output  3  channel that result was converted from
result_valid  output  1  one-cycle pulse when result/result_chan update
adc_convst  output  1  ADC CONVST
adc_sck  output  1  ADC SCK, idle low
adc_sdi  output  1  ADC SDI (config word, MSB first)
adc_sdo  input  1  ADC SDO (data, MSB first)

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE. adc_convst=0, adc_sck=0, adc_sdi=0. result=0, result_chan=0, result_valid=0. All counters=0. Internal first_frame=1, prev_chan=0. Reset mid-frame aborts the frame immediately with no valid pulse.
- States: IDLE, CONV, SHIFT, GAP.
- IDLE: outputs idle. If en=1, go to CONV next cycle and latch cur_chan<=chan. chan is sampled only at this point; later changes affect the next frame only.
- CONV: adc_convst=1 for exactly CONV_CYCLES cycles, then adc_convst=0 and go to SHIFT.
- Config word (6 bits, sent MSB first):
  - S/D=1, O/S=cur_chan[0], S1=cur_chan[2], S0=cur_chan[1], UNI=1, SLP=0.
  - Example: chan=5 gives 6'b1_1_1_0_1_0.
- SHIFT: 12 SCK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
  - adc_sdi is set to bit k during the low phase of period k (k=0..11). Bits 6..11 drive 0.
  - adc_sdo is sampled in the same clk cycle adc_sck goes 0->1. It shifts into an internal 12-bit shift register, MSB first.
  - The shift lasts exactly 24*CLK_DIV cycles. adc_sck returns low at its end.
- End of SHIFT, in the cycle entering GAP:
  - If first_frame=0: result<=shifted word, result_chan<=prev_chan, and result_valid=1 for exactly that one cycle.
  - If first_frame=1: no pulse.
  - In both cases prev_chan<=cur_chan and first_frame<=0.
  - This is the LTC2308 one-frame pipeline: data read in frame N belongs to the config sent in frame N-1.
- GAP: adc_convst=0 and adc_sck=0 for GAP_CYCLES cycles. Then go to CONV and latch chan if en=1; otherwise go to IDLE.
- Frame length with en held high = CONV_CYCLES + 24*CLK_DIV + GAP_CYCLES. Defaults give 80+48+2 = 130 cycles.
- Channel change latency: a new chan value latched at frame N's start appears on result at the end of frame N+1 (≤3 frames from the chan change).
- en deassert: the current frame always completes, including its valid pulse. first_frame is not re-armed. After a restart, the first result is tagged with the last channel sent before the stop.
- result and result_chan change only on result_valid cycles.

Test Plan:
- Reset then en=1, chan=0, ADC model returns 12'hA5C → adc_convst high 80 cycles, 12 SCK pulses; first frame gives no result_valid; second frame gives result=12'hA5C, result_chan=0, result_valid high one cycle at cycle 260 after en.
- chan=5 held → SDI bits across SCK rising edges = 1,1,1,0,1,0,0,0,0,0,0,0; SCK period 4 clks, idle low.
- chan switches 1→0 mid-CONV of frame N, model returns ch1=12'h950 and ch0=12'h3E8 → frame N+1 reports result_chan=1, 12'h950; frame N+2 reports result_chan=0, 12'h3E8.
- en dropped mid-SHIFT → frame finishes with valid pulse, state returns to IDLE, adc_convst stays 0 for 1000 cycles.
- reset_n low for 1 cycle mid-SHIFT → next cycle all outputs 0, no result_valid, next frame restarts from CONV with first_frame suppression.
- CLK_DIV=1, CONV_CYCLES=4, GAP_CYCLES=0 → frame exactly 28 cycles; back-to-back valid pulses spaced 28 cycles apart; SDO values 12'h000 and 12'hFFF captured exactly.

Source files
------------

// File: rtl/adc_ltc2308_ctrl.sv
// LTC2308 serial master: free-running convert/shift frames with a
// one-frame result pipeline, tagging each word with its channel.
module adc_ltc2308_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [2:0]  chan,
  output logic [11:0] result,
  output logic [2:0]  result_chan,
  output logic        result_valid,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo
);

  typedef enum logic [1:0] {
    IDLE, CONV, SHIFT, GAP
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  div_q;
  logic        hi_q;
  logic [3:0]  bit_q;
  logic [2:0]  cur_q;
  logic [2:0]  prev_q;
  logic        first_q;
  logic [11:0] sr_q;
  logic [11:0] res_q;
  logic [2:0]  rc_q;
  logic        vld_q;
  logic        convst_q;
  logic        sck_q;
  logic        sdi_q;

  logic [11:0] cfg_w;
  logic [3:0]  nb;
  logic        div_end;
  logic        shift_end;
  logic        gap_end;

  // Config word padded to 12 SCK periods; bits 6..11 go out as 0.
  assign cfg_w = {1'b1, cur_q[0], cur_q[2], cur_q[1],
                  1'b1, 1'b0, 6'b0};
  assign nb = bit_q + 4'd1;
  assign div_end = (div_q == 8'(CLK_DIV - 1));
  assign shift_end = (state_q == SHIFT) && div_end
                   && hi_q && (bit_q == 4'd11);
  assign gap_end =
    ((state_q == GAP) && (cnt_q == 16'(GAP_CYCLES - 1)))
    || (shift_end && (GAP_CYCLES == 0));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      hi_q     <= 1'b0;
      bit_q    <= '0;
      cur_q    <= '0;
      prev_q   <= '0;
      first_q  <= 1'b1;
      sr_q     <= '0;
      res_q    <= '0;
      rc_q     <= '0;
      vld_q    <= 1'b0;
      convst_q <= 1'b0;
      sck_q    <= 1'b0;
      sdi_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (en) begin
            state_q  <= CONV;
            cur_q    <= chan;
            convst_q <= 1'b1;
            cnt_q    <= '0;
          end
        end
        CONV: begin
          if (cnt_q == 16'(CONV_CYCLES - 1)) begin
            state_q  <= SHIFT;
            convst_q <= 1'b0;
            cnt_q    <= '0;
            div_q    <= '0;
            hi_q     <= 1'b0;
            bit_q    <= '0;
            sck_q    <= 1'b0;
            sdi_q    <= cfg_w[11];
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_q <= div_q + 8'd1;
          end else begin
            div_q <= '0;
            if (!hi_q) begin
              hi_q  <= 1'b1;
              sck_q <= 1'b1;
              sr_q  <= {sr_q[10:0], adc_sdo};
            end else if (bit_q == 4'd11) begin
              // Data read now belongs to the previous frame's config.
              hi_q    <= 1'b0;
              sck_q   <= 1'b0;
              sdi_q   <= 1'b0;
              state_q <= GAP;
              cnt_q   <= '0;
              vld_q   <= !first_q;
              if (!first_q) begin
                res_q <= sr_q;
                rc_q  <= prev_q;
              end
              prev_q  <= cur_q;
              first_q <= 1'b0;
            end else begin
              hi_q  <= 1'b0;
              sck_q <= 1'b0;
              bit_q <= nb;
              sdi_q <= cfg_w[4'd11 - nb];
            end
          end
        end
        GAP: begin
          cnt_q <= cnt_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
      if (gap_end) begin
        cnt_q <= '0;
        if (en) begin
          state_q  <= CONV;
          cur_q    <= chan;
          convst_q <= 1'b1;
        end else begin
          state_q <= IDLE;
        end
      end
    end
  end

  assign result       = res_q;
  assign result_chan  = rc_q;
  assign result_valid = vld_q;
  assign adc_convst   = convst_q;
  assign adc_sck      = sck_q;
  assign adc_sdi      = sdi_q;

endmodule
